sys_ctrl_seq: RTL

- Parametrised successor to the systolic-array weight/partial-sum mode controller.
- Sequences one full tile operation: weight preload of ROWS rows, streaming of K activation vectors, pipeline drain, done pulse.
- Produces PE enables, the weight-row select, and a latency-matched partial-sum valid strobe.
- Sits between the tile scheduler (start/abort) and the ROWS x COLS PE array.

---
 rtl/sys_ctrl_seq.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sys_ctrl_seq.sv
// Tile sequencer for the systolic array: weight preload, activation stream, drain, done pulse.
// Latency: minimum 1 + ROWS + k_len + LAT cycles from accepted start to done.
// Backpressure: w_valid/act_valid gaps stall LOAD_W/COMPUTE in place; DRAIN never stalls.
module sys_ctrl_seq #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int K_W  = 8,
    parameter int LAT  = ROWS + COLS - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [K_W-1:0]          k_len,
    input  logic                    w_valid,
    input  logic                    act_valid,
    output logic                    w_load,
    output logic [$clog2(ROWS)-1:0] w_row_sel,
    output logic                    act_ready,
    output logic                    pe_en,
    output logic                    act_zero,
    output logic                    psum_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int RW = $clog2(ROWS);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [RW-1:0]  row_cnt_q, row_cnt_d;
    logic [K_W-1:0] k_cnt_q, k_cnt_d;
    logic [K_W-1:0] k_reg_q, k_reg_d;
    logic [DW-1:0]  drain_cnt_q, drain_cnt_d;
    logic [LAT-1:0] pipe_q, pipe_d;
    logic           push_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            k_cnt_q     <= '0;
            k_reg_q     <= '0;
            drain_cnt_q <= '0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            k_cnt_q     <= k_cnt_d;
            k_reg_q     <= k_reg_d;
            drain_cnt_q <= drain_cnt_d;
            pipe_q      <= pipe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        k_cnt_d     = k_cnt_q;
        k_reg_d     = k_reg_q;
        drain_cnt_d = drain_cnt_q;
        pipe_d      = pipe_q;
        push_vld    = 1'b0;
        w_load      = 1'b0;
        w_row_sel   = '0;
        act_ready   = 1'b0;
        pe_en       = 1'b0;
        act_zero    = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort && (k_len != '0)) begin
                    k_reg_d     = k_len;
                    row_cnt_d   = '0;
                    k_cnt_d     = '0;
                    drain_cnt_d = '0;
                    state_d     = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                w_load    = 1'b1;
                w_row_sel = row_cnt_q;
                if (w_valid) begin
                    if (row_cnt_q == RW'(ROWS - 1)) begin
                        row_cnt_d = '0;
                        state_d   = S_COMPUTE;
                    end else begin
                        row_cnt_d = row_cnt_q + RW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                act_ready = 1'b1;
                pe_en     = act_valid;
                push_vld  = act_valid;
                if (act_valid) begin
                    if (k_cnt_q == k_reg_q - K_W'(1)) begin
                        k_cnt_d = '0;
                        state_d = S_DRAIN;
                    end else begin
                        k_cnt_d = k_cnt_q + K_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                pe_en    = 1'b1;
                act_zero = 1'b1;
                if (drain_cnt_q == DW'(LAT - 1)) begin
                    drain_cnt_d = '0;
                    state_d     = S_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            S_DONE: begin
                done    = !abort;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The valid pipe tracks the PE pipeline, so it only moves when the PEs advance.
        if (pe_en) begin
            pipe_d = (pipe_q << 1) | LAT'(push_vld);
        end

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            row_cnt_d   = '0;
            k_cnt_d     = '0;
            drain_cnt_d = '0;
            pipe_d      = '0;
        end
    end

    assign psum_valid = pipe_q[LAT-1] & pe_en;
    assign busy       = (state_q != S_IDLE);

endmodule
